gradient_scheduler: RTL
=======================

// Module: gradient_scheduler
// PURPOSE
//  Time-shares one gradient_image engine among NUM_IMAGES pyramid-level image BRAMs.
//  Collects per-image requests, picks one round-robin, and pulses the engine start.
//  Routes engine reads/pixels to the selected source BRAM and x/y write enables to its dest BRAM pair.
//  Reports per-image completion; a watchdog aborts hung jobs.
// PARAMETERS
//  NUM_IMAGES      4      number of requesters (source/dest BRAM sets), >=2
//  BIT_DEPTH       8      pixel width
//  WIDTH           64     image width, pixels
//  HEIGHT          64     image height, pixels
//  ADDR_W          $clog2(WIDTH*HEIGHT)  pixel address width
//  TIMEOUT_CYCLES  65536  max RUN cycles before abort
// PORTS
//  clk_in             in   1                  system clock
//  rst_in             in   1                  sync reset, ACTIVE-LOW
//  req_in             in   NUM_IMAGES         per-image request pulses
//  busy_out           out  1                  state != IDLE
//  active_idx_out     out  $clog2(NUM_IMAGES) index being served
//  done_out           out  NUM_IMAGES         1-cycle completion pulse, one-hot
//  error_out          out  1                  1-cycle watchdog abort pulse
//  grad_start_out     out  1                  engine start pulse
//  grad_done_in       in   1                  engine done
//  eng_read_addr_in   in   ADDR_W             engine read address
//  eng_read_valid_in  in   1                  engine read enable
//  img_read_addr_out  out  ADDR_W             shared read address to all source BRAMs
//  img_read_en_out    out  NUM_IMAGES         one-hot source BRAM enable
//  img_pixel_in       in   NUM_IMAGES*BIT_DEPTH  source BRAM douta, image i at [i*BIT_DEPTH +: BIT_DEPTH]
//  eng_pixel_out      out  BIT_DEPTH          selected pixel to engine
//  eng_x_valid_in     in   1                  engine x-gradient write valid
//  eng_y_valid_in     in   1                  engine y-gradient write valid
//  x_we_out           out  NUM_IMAGES         one-hot x dest BRAM write enable
//  y_we_out           out  NUM_IMAGES         one-hot y dest BRAM write enable
// BEHAVIOUR
//  - Reset (rst_in==0 at edge): state=IDLE, pending=0, rr_ptr=0, active_idx=0, timer=0.
//    All registered outputs 0. Combinational enables 0 while IDLE. Reset mid-job abandons it with no done/error.
//  - pending[i] is set on any edge with req_in[i]=1, and cleared when i is launched.
//    Requests coalesce: a req for an already-pending i has no effect.
//    A req for the active i during LAUNCH/RUN/COMPLETE re-sets pending[i], so i runs again later.
//  - FSM IDLE -> LAUNCH -> RUN -> COMPLETE -> IDLE.
//    IDLE: if pending!=0, select the first set bit searching from rr_ptr upward with wrap.
//      Register active_idx and clear its pending bit -> LAUNCH.
//    LAUNCH: grad_start_out=1 for exactly this cycle -> RUN; timer=0.
//    RUN: on grad_done_in=1 -> COMPLETE.
//      Else if timer==TIMEOUT_CYCLES-1 -> IDLE with error_out=1 for 1 cycle.
//      Else timer++.
//    COMPLETE: done_out[active_idx]=1 for 1 cycle; rr_ptr=active_idx+1 (mod NUM_IMAGES) -> IDLE.
//    Abort also advances rr_ptr.
//  - Latency: req_in[i] at edge E0 -> pending; LAUNCH (grad_start_out high) E1..E2; RUN from E2.
//    grad_done_in sampled at edge En -> done_out high En..En+1. Min idle gap between jobs is 1 cycle.
//  - Routing is combinational and valid only in LAUNCH/RUN/COMPLETE:
//      img_read_addr_out = eng_read_addr_in (always).
//      img_read_en_out   = eng_read_valid_in ? onehot(active_idx) : 0.
//      eng_pixel_out     = img_pixel_in slice active_idx.
//        Select is held through COMPLETE, which covers the 2-cycle BRAM latency of the last reads.
//      x_we_out / y_we_out = eng_x/y_valid_in ? onehot(active_idx) : 0.
//    In IDLE all enables are 0 and engine writes are dropped.
//  - grad_done_in outside RUN is ignored. Timer is $clog2(TIMEOUT_CYCLES)+1 bits, no wrap.
// TESTING
//  - req_in=4'b0100 one cycle, done after 50 RUN cycles -> grad_start_out 1 cycle at E1, active_idx_out=2,
//    img_read_en_out=4'b0100 on reads, done_out=4'b0100 one cycle.
//  - req_in=4'b1011 same cycle, after reset -> launch order 0,1,3; exactly one done_out pulse each, one-hot.
//  - Fairness: idx1 just completed, pending {0,3} -> 3 served before 0.
//  - BRAM i preloaded with constant 8'h10*(i+1), active idx 3 -> eng_pixel_out==8'h40 every read.
//    x/y writes hit only x_we_out[3]/y_we_out[3].
//  - TIMEOUT_CYCLES=100, grad_done_in held 0 -> error_out at RUN cycle 100, no done_out, returns to IDLE,
//    next pending served.
//  - rst_in=0 mid-RUN, and re-req of active idx during RUN -> after reset all outputs 0, pending 0;
//    without reset, the re-request runs a second job.

Source files
------------

// File: rtl/gradient_scheduler.sv
// Round-robin arbiter sharing one gradient engine across several image BRAM sets.
// Routes engine reads, pixels and gradient write enables to the job being served.
module gradient_scheduler #(
  parameter int NUM_IMAGES     = 4,
  parameter int BIT_DEPTH      = 8,
  parameter int WIDTH          = 64,
  parameter int HEIGHT         = 64,
  parameter int ADDR_W         = $clog2(WIDTH*HEIGHT),
  parameter int TIMEOUT_CYCLES = 65536,
  localparam int IDX_W         = $clog2(NUM_IMAGES)
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [NUM_IMAGES-1:0]           req_in,
  output logic                            busy_out,
  output logic [IDX_W-1:0]                active_idx_out,
  output logic [NUM_IMAGES-1:0]           done_out,
  output logic                            error_out,
  output logic                            grad_start_out,
  input  logic                            grad_done_in,
  input  logic [ADDR_W-1:0]               eng_read_addr_in,
  input  logic                            eng_read_valid_in,
  output logic [ADDR_W-1:0]               img_read_addr_out,
  output logic [NUM_IMAGES-1:0]           img_read_en_out,
  input  logic [NUM_IMAGES*BIT_DEPTH-1:0] img_pixel_in,
  output logic [BIT_DEPTH-1:0]            eng_pixel_out,
  input  logic                            eng_x_valid_in,
  input  logic                            eng_y_valid_in,
  output logic [NUM_IMAGES-1:0]           x_we_out,
  output logic [NUM_IMAGES-1:0]           y_we_out
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    COMPLETE
  } state_t;

  state_t                  state;
  logic [NUM_IMAGES-1:0]   pending;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        active_idx;
  logic [TMR_W-1:0]        timer;
  logic [IDX_W-1:0]        pick;
  logic [IDX_W-1:0]        cand;
  logic [IDX_W-1:0]        next_idx;
  logic [NUM_IMAGES-1:0]   onehot;
  logic [NUM_IMAGES-1:0]   clr;
  logic                    routed;
  int                      j;

  // Descending scan so the nearest set bit at or after rr_ptr wins
  always_comb begin
    pick = '0;
    cand = '0;
    j    = 0;
    for (int k = NUM_IMAGES - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_IMAGES) j = j - NUM_IMAGES;
      cand = IDX_W'(j);
      if (pending[cand]) pick = cand;
    end
  end

  always_comb begin
    clr = '0;
    if (state == IDLE && |pending)
      clr = NUM_IMAGES'(1) << pick;
  end

  assign next_idx = (active_idx == IDX_W'(NUM_IMAGES - 1)) ?
                    '0 : active_idx + 1'b1;
  assign onehot   = NUM_IMAGES'(1) << active_idx;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state          <= IDLE;
      pending        <= '0;
      rr_ptr         <= '0;
      active_idx     <= '0;
      timer          <= '0;
      done_out       <= '0;
      error_out      <= 1'b0;
      grad_start_out <= 1'b0;
    end else begin
      pending        <= (pending & ~clr) | req_in;
      done_out       <= '0;
      error_out      <= 1'b0;
      grad_start_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|pending) begin
            active_idx     <= pick;
            grad_start_out <= 1'b1;
            state          <= LAUNCH;
          end
        end
        LAUNCH: begin
          timer <= '0;
          state <= RUN;
        end
        RUN: begin
          if (grad_done_in) begin
            done_out <= onehot;
            state    <= COMPLETE;
          end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            error_out <= 1'b1;
            rr_ptr    <= next_idx;
            state     <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        COMPLETE: begin
          rr_ptr <= next_idx;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Select stays on through COMPLETE to catch the last in-flight BRAM reads
  assign routed            = (state != IDLE);
  assign busy_out          = routed;
  assign active_idx_out    = active_idx;
  assign img_read_addr_out = eng_read_addr_in;
  assign img_read_en_out   = (routed && eng_read_valid_in) ? onehot : '0;
  assign x_we_out          = (routed && eng_x_valid_in) ? onehot : '0;
  assign y_we_out          = (routed && eng_y_valid_in) ? onehot : '0;
  assign eng_pixel_out     = img_pixel_in[active_idx*BIT_DEPTH +: BIT_DEPTH];

endmodule
